// File: rtl/aexm_pkg.sv
// Shared definitions for the aexm data-side memory responder.
package aexm_pkg;

    // Wait-state counter width (WAIT ranges 0..7)
    localparam int unsigned WAIT_W = 3;

    // Responder FSM state encoding
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WAITS = 2'd2,
        ST_ACK   = 2'd3
    } state_t;

    // Big-endian byte-lane selects: bit3 = dat[31:24] = byte 0
    localparam logic [3:0] SEL_B0 = 4'h8;
    localparam logic [3:0] SEL_B1 = 4'h4;
    localparam logic [3:0] SEL_B2 = 4'h2;
    localparam logic [3:0] SEL_B3 = 4'h1;
    localparam logic [3:0] SEL_H0 = 4'hC;
    localparam logic [3:0] SEL_H1 = 4'h3;
    localparam logic [3:0] SEL_W  = 4'hF;

endpackage

// File: rtl/aexm_dram_bank.sv
// Single-port synchronous data RAM, four byte-write enables, read-first.
module aexm_dram_bank #(
    parameter int unsigned AW = 12,
    parameter int unsigned DW = 32
) (
    input  logic          gclk,
    input  logic          grst,
    input  logic [AW-1:0] i_addr,
    input  logic          i_re,
    input  logic [3:0]    i_we,
    input  logic [DW-1:0] i_wdata,
    output logic [DW-1:0] o_rdata
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rdata;

    // Byte-lane writes; lanes with a clear enable keep their old contents
    always_ff @(posedge gclk) begin
        for (int b = 0; b < 4; b++) begin
            if (i_we[b]) begin
                r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
            end
        end
    end

    // Registered read port; holds its value when no read is launched
    always_ff @(posedge gclk) begin
        if (grst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/aexm_dmem_resp.sv
// Data-side bus responder: services core loads/stores from local byte-lane RAM
// with a single-cycle acknowledge, using the precycle address to hide read latency.
module aexm_dmem_resp
    import aexm_pkg::*;
#(
    parameter int unsigned DW   = 32,
    parameter int unsigned AW   = 12,
    parameter int unsigned WAIT = 0
) (
    input  logic          gclk,
    input  logic          grst,
    input  logic [AW-1:0] pre_adr_i,
    input  logic          dwb_stb_i,
    input  logic          dwb_wre_i,
    input  logic [3:0]    dwb_sel_i,
    input  logic [AW-1:0] dwb_adr_i,
    input  logic [DW-1:0] dwb_dat_i,
    output logic [DW-1:0] dwb_dat_o,
    output logic          dwb_ack_o,
    output logic          busy_o
);

    localparam logic [WAIT_W-1:0] WAIT_LD  = WAIT_W'(WAIT);
    localparam state_t            ST_SERVE = (WAIT == 0) ? ST_ACK : ST_WAITS;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [AW-1:0]       r_pre_q;
    logic [AW-1:0]       r_adr;
    logic                r_wre;
    logic                r_dirty;
    logic                r_ack;
    logic                r_busy;
    logic [WAIT_W-1:0]   r_wcnt;

    logic                w_accept;
    logic                w_hit;
    logic                w_ack_nxt;
    logic                w_busy_nxt;
    logic                w_ram_re;
    logic [3:0]          w_ram_we;
    logic [AW-1:0]       w_ram_addr;
    logic [DW-1:0]       w_rdata;

    // A write since the last read invalidates the speculative precycle fetch
    assign w_accept = (r_state == ST_IDLE) && dwb_stb_i;
    assign w_hit    = !r_dirty && (r_pre_q == dwb_adr_i);

    // State register
    always_ff @(posedge gclk) begin
        if (grst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (dwb_stb_i) begin
                    w_state_nxt = (dwb_wre_i || w_hit) ? ST_SERVE : ST_FETCH;
                end
            end
            ST_FETCH: w_state_nxt = ST_SERVE;
            ST_WAITS: begin
                if (r_wcnt <= WAIT_W'(1)) begin
                    w_state_nxt = ST_ACK;
                end
            end
            ST_ACK:   w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Output/datapath decode: RAM port control and next values of the bus outputs
    always_comb begin
        w_ack_nxt  = (w_state_nxt == ST_ACK);
        w_busy_nxt = (w_state_nxt != ST_IDLE);
        w_ram_we   = 4'h0;
        w_ram_re   = 1'b0;
        w_ram_addr = r_adr;
        if (r_state == ST_IDLE) begin
            w_ram_addr = (dwb_stb_i && dwb_wre_i) ? dwb_adr_i : r_pre_q;
            if (w_accept && dwb_wre_i && !grst) begin
                w_ram_we = dwb_sel_i;
            end
            w_ram_re = w_ack_nxt && !dwb_wre_i;
        end else if (r_state != ST_ACK) begin
            w_ram_re = w_ack_nxt && !r_wre;
        end
    end

    // Request capture, precycle address, wait counter and registered outputs
    always_ff @(posedge gclk) begin
        if (grst) begin
            r_pre_q <= '0;
            r_adr   <= '0;
            r_wre   <= 1'b0;
            r_dirty <= 1'b0;
            r_wcnt  <= '0;
            r_ack   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_ack  <= w_ack_nxt;
            r_busy <= w_busy_nxt;
            if (r_state == ST_IDLE) begin
                r_pre_q <= pre_adr_i;
            end
            if (w_accept) begin
                r_adr   <= dwb_adr_i;
                r_wre   <= dwb_wre_i;
                r_dirty <= dwb_wre_i;
            end
            if (w_state_nxt == ST_WAITS && r_state != ST_WAITS) begin
                r_wcnt <= WAIT_LD;
            end else if (r_state == ST_WAITS) begin
                r_wcnt <= r_wcnt - WAIT_W'(1);
            end
        end
    end

    aexm_dram_bank #(
        .AW (AW),
        .DW (DW)
    ) u_bank (
        .gclk    (gclk),
        .grst    (grst),
        .i_addr  (w_ram_addr),
        .i_re    (w_ram_re),
        .i_we    (w_ram_we),
        .i_wdata (dwb_dat_i),
        .o_rdata (w_rdata)
    );

    assign dwb_dat_o = w_rdata;
    assign dwb_ack_o = r_ack;
    assign busy_o    = r_busy;

endmodule

// File: doc/aexm_dmem_resp.md
# aexm_dmem_resp

Data-side bus responder for the aexm core: receives the execution unit's early (precycle) address, full bus address, byte selects, write enable and store data, and services them from local byte-lane RAM. Returns the raw 32-bit read word with a single-cycle acknowledge. The core's load path does lane alignment. Sits between the core data port and on-chip data memory, replacing an external wishbone slave.

## Interface
- DW, 32: data width; fixed at 32, other values unsupported.
- AW, 12: word-address bits; memory depth is 2^AW words.
- WAIT, 0: extra wait cycles inserted before every ack (0–7).

Ports:
- gclk  in  1  clock.
- grst  in  1  reset, synchronous, active-high.
- pre_adr_i  in  AW  precycle word address, valid one cycle before the matching stb.
- dwb_stb_i  in  1  request strobe; held high until ack.
- dwb_wre_i  in  1  1 = write, 0 = read; stable while stb is high.
- dwb_sel_i  in  4  byte lanes, big-endian: bit3 = dat[31:24] (byte 0) … bit0 = dat[7:0].
- dwb_adr_i  in  AW  word address of the request.
- dwb_dat_i  in  32  store data, already lane-replicated by the core.
- dwb_dat_o  out  32  read data; valid only while ack is high, otherwise holds last value.
- dwb_ack_o  out  1  one-cycle completion pulse.
- busy_o  out  1  high in any state except IDLE.

## Operation
- Every cycle in IDLE, pre_adr_i is registered into pre_q and launches a RAM read at pre_q.
- States: IDLE, FETCH, WAITS, ACK.
- IDLE, stb=1, read, pre_q==dwb_adr_i (hit):
  - RAM word is already in flight.
  - WAIT=0: go to ACK.
  - WAIT>0: load wait counter with WAIT, go to WAITS.
- IDLE, stb=1, read, miss: re-launch the read at dwb_adr_i, go to FETCH.
- FETCH: next cycle, treat as hit (to ACK, or to WAITS if WAIT>0).
- IDLE, stb=1, write:
  - Write only lanes with sel bit set; other lanes keep their old contents.
  - sel=4'h0 writes nothing but still completes.
  - Then to ACK, or WAITS if WAIT>0.
  - Hit/miss is irrelevant for writes.
- WAITS: decrement counter; at 1 go to ACK.
- ACK:
  - ack=1 for exactly this cycle.
  - Reads: dwb_dat_o = RAM word.
  - Writes: dwb_dat_o is unchanged.
  - Next state is IDLE unconditionally; stb in the ACK cycle is ignored.
  - A new request is accepted no earlier than the cycle after ACK.
- Read-after-write to the same address, back-to-back, returns the newly written bytes. RAM is read-first, so the pre_q read launched during a write cycle is re-fetched. Any write forces the next read to take the miss path.
- Reset: state=IDLE, dwb_ack_o=0, dwb_dat_o=32'h0, busy_o=0, pre_q=0, wait counter=0. RAM contents are not cleared.

## Timing
- Request seen at edge N (stb high in cycle N).
- Read hit: ack in cycle N+1+WAIT.
- Read miss: ack in cycle N+2+WAIT.
- Write: RAM updated at edge N+1; ack in cycle N+1+WAIT.
- Minimum request spacing: 2 cycles (hit/write, WAIT=0).
- grst asserted in any state: at the next edge, state=IDLE and ack=0. A pending write that has not yet reached its write edge is dropped.
- stb dropped before ack (protocol violation): the FSM still completes and pulses ack; the bench flags it as an error.

## Structure
- Shared package aexm_pkg holds:
  - state encoding constants (IDLE=2'd0, FETCH=2'd1, WAITS=2'd2, ACK=2'd3);
  - lane-select constants (SEL_B0=4'h8 … SEL_W=4'hF);
  - WAIT counter width (3).
- One sub-module: aexm_dram_bank.
  - Synchronous 2^AW x 32 RAM, four byte-write enables, read-first, single port.
  - Address mux (pre_q / dwb_adr_i) lives in aexm_dmem_resp.

## Test plan
- Read hit, WAIT=0: preload word 5 = 32'hDEADBEEF; pre_adr=5 in cycle 0, stb/adr=5 in cycle 1 -> ack in cycle 2, dat_o=32'hDEADBEEF.
- Read miss: pre_adr=3, stb/adr=5 -> ack one cycle later than the hit case, dat_o=32'hDEADBEEF.
- Byte write: word 7 = 32'h11223344; write sel=4'h4, dat=32'hAAAAAAAA -> then read word 7 = 32'h11AA3344.
- Halfword + no-lane: sel=4'h3, dat=32'h0000BEEF on word 7 -> 32'h11AABEEF; then sel=4'h0 -> unchanged, ack still pulses once.
- WAIT=3: read hit -> ack exactly 4 cycles after the stb edge; busy_o high for 4 cycles.
- Reset mid-op: WAIT=3, grst in the second WAITS cycle -> no ack, dat_o=0, busy_o=0; earlier RAM writes are preserved.
